// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register with next-PC selection, conditional branches, stall and circular return-address stack
module pc_sequencer #(
  parameter int PC_WIDTH = 32,
  parameter int OFF_WIDTH = 8,
  parameter int WORD_SHIFT = 2,
  parameter int RAS_DEPTH = 4,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        STALL,
  input  logic [2:0]                  CTRL,
  input  logic                        ZERO,
  input  logic [OFF_WIDTH-1:0]        OFFSET,
  output logic [PC_WIDTH-1:0]         PC,
  output logic [PC_WIDTH-1:0]         PC_PLUS4,
  output logic [$clog2(RAS_DEPTH):0]  RAS_COUNT,
  output logic                        RAS_UNDERFLOW,
  output logic                        RAS_OVERFLOW
);
  localparam int AW = $clog2(RAS_DEPTH);
  localparam logic [2:0] C_JUMP = 3'b001;
  localparam logic [2:0] C_BEQ  = 3'b010;
  localparam logic [2:0] C_BNE  = 3'b011;
  localparam logic [2:0] C_CALL = 3'b100;
  localparam logic [2:0] C_RET  = 3'b101;
  localparam logic [PC_WIDTH-1:0] INC = PC_WIDTH'(1) << WORD_SHIFT;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(RAS_DEPTH);
  logic [PC_WIDTH-1:0] pc_q, pc_d, off_ext, target, top;
  logic [PC_WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic uf_q, uf_d, of_q, of_d;
  logic empty, full, push, pop, taken;
  assign PC = pc_q;
  assign PC_PLUS4 = pc_q + INC;
  assign RAS_COUNT = cnt_q;
  assign RAS_UNDERFLOW = uf_q;
  assign RAS_OVERFLOW = of_q;
  // Next-PC select and stack bookkeeping; a RET on an empty stack falls through to PC+4
  always_comb begin
    off_ext = {{(PC_WIDTH-OFF_WIDTH){OFFSET[OFF_WIDTH-1]}}, OFFSET};
    target = PC_PLUS4 + (off_ext << WORD_SHIFT);
    top = ras_q[ptr_q - AW'(1)];
    empty = cnt_q == '0;
    full = cnt_q == FULL_CNT;
    push = !STALL && CTRL == C_CALL;
    pop = !STALL && CTRL == C_RET && !empty;
    taken = CTRL == C_JUMP || CTRL == C_CALL || (CTRL == C_BEQ && ZERO) || (CTRL == C_BNE && !ZERO);
    pc_d = STALL ? pc_q : pop ? top : taken ? target : PC_PLUS4;
    ptr_d = push ? ptr_q + AW'(1) : pop ? ptr_q - AW'(1) : ptr_q;
    cnt_d = push ? (full ? cnt_q : cnt_q + (AW+1)'(1)) : pop ? cnt_q - (AW+1)'(1) : cnt_q;
    uf_d = !STALL && CTRL == C_RET && empty;
    of_d = push && full;
  end
  // Control state: PC, stack pointer, occupancy and one-cycle flag pulses
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pc_q <= RESET_VECTOR;
      ptr_q <= '0;
      cnt_q <= '0;
      uf_q <= 1'b0;
      of_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      uf_q <= uf_d;
      of_q <= of_d;
    end
  end
  // Stack storage needs no reset; a push when full overwrites the oldest slot
  always_ff @(posedge CLK) begin
    if (push) ras_q[ptr_q] <= PC_PLUS4;
  end
endmodule
